uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Character FIFO and send-handshake sequencer between the core's simulated-UART character stream and the UART transmit controller. It absorbs bursts of characters written by the CPU, presents them one at a time on a SEND/READY handshake, and counts characters lost to overflow. It runs on the fast board clock, the same clock as the transmit controller, and lets that controller drain output without stalling the core.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, 4..256.
- AW, $clog2(DEPTH): pointer width (derived; do not override).

Ports:
- clk  in  1  board clock.
- resetn  in  1  reset; synchronous, active-low; clock clk.
- in_valid  in  1  one-cycle character strobe from upstream.
- in_data  in  8  character, valid with in_valid.
- in_ready  out  1  FIFO not full (combinational, = !full).
- tx_ready  in  1  transmit controller idle/ready.
- tx_send  out  1  request to transmit tx_data (registered).
- tx_data  out  8  character being offered (registered).
- level  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a character was dropped since reset.
- drop_count  out  8  dropped characters, saturates at 255.

## Operation
- FIFO: circular buffer, read/write pointers AW+1 bits wide. Empty when pointers are equal. Full when the low AW bits are equal and the MSBs differ.
- Push: in_valid && !full writes in_data at the write pointer and increments it.
- Drop: in_valid && full writes nothing, sets overflow, and increments drop_count (saturates at 255).
- Push while full is rejected even if a pop occurs in the same cycle. Push and pop in the same non-full cycle leave level unchanged.
- Sequencer FSM:
  - IDLE: if !empty && tx_ready, load the head into tx_data, assert tx_send, pop (see Configuration), go to SEND.
  - SEND: hold tx_send=1 and tx_data stable until tx_ready is sampled 0 (accepted), then clear tx_send and go to WAIT.
  - WAIT: stay until tx_ready is sampled 1, then go to IDLE.
- tx_data only changes on the IDLE→SEND transition.
- Reset values: state IDLE, tx_send 0, tx_data 8'h00, level 0, overflow 0, drop_count 0, pointers 0. in_ready reads 1 after reset.
- Reset mid-operation empties the FIFO and drops tx_send. A character already accepted by the controller still completes on the line; that is the controller's concern.

## Timing
- Push sampled at edge E0 with tx_ready=1 and FSM in IDLE: tx_send rises after E1.
- Minimum spacing between two sends is 3 cycles (IDLE, SEND, WAIT) plus the controller's busy time.
- level updates on the edge that performs the push or pop.
- in_ready deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first subsequent pop.
- tx_ready low while in IDLE: the FSM holds in IDLE and does not pop.

## Configuration
- UART_TX_CRLF_EN defined: CR is inserted before LF.
  - In IDLE, when the head is 8'h0A and the internal cr_done flag is 0, send 8'h0D without popping and set cr_done.
  - The next IDLE pass sends 8'h0A, pops, and clears cr_done.
  - cr_done resets to 0.
  - The inserted CR does not count toward level.
- UART_TX_CRLF_EN undefined: characters pass byte-exact. cr_done logic is absent.

## Test plan
- Single char: push 8'h41 with tx_ready=1 → tx_send rises 1 cycle later with tx_data=8'h41. Model drops tx_ready 2 cycles later → tx_send=0 and level=0.
- Burst/full: tx_ready=0, push 18 chars into DEPTH=16 → level=16, in_ready=0, overflow=1, drop_count=2. Release tx_ready → first 16 chars emerge in order.
- Saturation: 300 pushes while full → drop_count=255.
- Handshake hold: controller delays the tx_ready fall by 10 cycles → tx_send and tx_data remain stable for all 10 cycles, and exactly one pop occurs.
- Reset mid-burst: resetn=0 for 1 cycle while 5 chars are queued and tx_send=1 → next cycle tx_send=0, level=0, overflow=0. A subsequent push of 8'h55 is sent normally.
- CRLF (with UART_TX_CRLF_EN): push 8'h0A → sends 8'h0D then 8'h0A, with level going 1→1→0. Without the macro → only 8'h0A is sent.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: character input, transmit handshake and status bundle for uart_tx_fifo.
// The FIFO itself connects through the slave modport. The upstream source and the
// transmit controller connect through the master modport.
interface uart_tx_fifo_if #(
    parameter int unsigned AW = 4
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          tx_ready;
    logic          tx_send;
    logic [7:0]    tx_data;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    drop_count;

    modport slave (
        input  in_valid, in_data, tx_ready,
        output in_ready, tx_send, tx_data, level, overflow, drop_count
    );

    modport master (
        output in_valid, in_data, tx_ready,
        input  in_ready, tx_send, tx_data, level, overflow, drop_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: character FIFO with SEND/READY sequencer and overflow accounting.
// Optional macro UART_TX_CRLF_EN inserts a CR ahead of every LF, without
// consuming a FIFO entry for the CR.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           resetn,
    uart_tx_fifo_if.slave  bus
);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_tx_send;
    logic [7:0]    r_tx_data;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_load;
    logic          w_send_nxt;
    logic [7:0]    w_load_data;
    logic [7:0]    w_head;
`ifdef UART_TX_CRLF_EN
    logic          r_cr_done;
    logic          w_cr_set;
    logic          w_cr_clr;
`endif

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_push  = bus.in_valid && !w_full;
    assign w_drop  = bus.in_valid && w_full;
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // Sequencer next state: offer the head in IDLE, hold in SEND until accepted,
    // then wait in WAIT for the controller to become ready again.
    always_comb begin
        w_state_nxt = r_state;
        w_send_nxt  = r_tx_send;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_load_data = w_head;
`ifdef UART_TX_CRLF_EN
        w_cr_set    = 1'b0;
        w_cr_clr    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty && bus.tx_ready) begin
                    w_load      = 1'b1;
                    w_send_nxt  = 1'b1;
                    w_state_nxt = S_SEND;
`ifdef UART_TX_CRLF_EN
                    // The LF stays at the head while its CR goes out first.
                    if (w_head == 8'h0A && !r_cr_done) begin
                        w_load_data = 8'h0D;
                        w_cr_set    = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_cr_clr = 1'b1;
                    end
`else
                    w_pop = 1'b1;
`endif
                end
            end
            S_SEND: begin
                if (!bus.tx_ready) begin
                    w_send_nxt  = 1'b0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.tx_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_send_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state and the registered send request and offered character.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_tx_send <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_send <= w_send_nxt;
            if (w_load) begin
                r_tx_data <= w_load_data;
            end
        end
    end

    // Read and write pointers. The extra MSB tells full apart from empty.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    // Character storage. It has no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= bus.in_data;
        end
    end

    // Overflow tracking: sticky flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

`ifdef UART_TX_CRLF_EN
    // Records that the CR for the LF at the head has already been sent.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cr_done <= 1'b0;
        end else if (w_cr_set) begin
            r_cr_done <= 1'b1;
        end else if (w_cr_clr) begin
            r_cr_done <= 1'b0;
        end
    end
`endif

    assign bus.in_ready   = !w_full;
    assign bus.tx_send    = r_tx_send;
    assign bus.tx_data    = r_tx_data;
    assign bus.level      = r_wptr - r_rptr;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a simple transmit-controller model.
// If UART_TX_CRLF_EN is defined, the bench expects the CR insertion behaviour.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.AW(4)) ifc ();

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    // tx_ready comes either from the directed stimulus or from the controller model.
    logic ctl_manual;
    logic man_ready;
    logic auto_ready;
    int   ctl_busy;
    assign ifc.tx_ready = ctl_manual ? man_ready : auto_ready;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];
    logic       prev_send = 1'b0;
    logic [7:0] held_data = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit exp_sent);
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        if (exp_sent) sb.push_back(d);
        step();
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_send(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ifc.tx_send) break;
        end
        check(name, int'(ifc.tx_send), 1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !ifc.tx_send && ifc.level == 5'd0) break;
        end
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_level"}, int'(ifc.level), 0);
        repeat (4) step();
    endtask

    // Controller model: accepts a request one cycle after seeing it, then stays busy.
    initial begin
        int bcnt;
        auto_ready = 1'b1;
        bcnt = 0;
        forever begin
            step();
            if (!resetn || ctl_manual) begin
                auto_ready = 1'b1;
                bcnt = 0;
            end else if (auto_ready && ifc.tx_send) begin
                auto_ready = 1'b0;
                bcnt = 0;
            end else if (!auto_ready) begin
                bcnt++;
                if (bcnt >= ctl_busy) auto_ready = 1'b1;
            end
        end
    end

    // Monitor: each new send must match the scoreboard head. An offered character must stay stable.
    always @(negedge clk) begin
        if (ifc.tx_send && !prev_send) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_send: got 0x%0h expected no send at %0t", ifc.tx_data, $time);
            end else begin
                check("tx_data", int'(ifc.tx_data), int'(sb.pop_front()));
            end
            held_data = ifc.tx_data;
        end else if (ifc.tx_send && prev_send) begin
            check("tx_data_hold", int'(ifc.tx_data), int'(held_data));
        end
        prev_send = ifc.tx_send;
    end

    initial begin
        resetn       = 1'b0;
        ctl_manual   = 1'b1;
        man_ready    = 1'b1;
        ctl_busy     = 2;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (3) step();
        resetn = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_tx_send", int'(ifc.tx_send), 0);
        check("rst_tx_data", int'(ifc.tx_data), 0);
        check("rst_level", int'(ifc.level), 0);
        check("rst_overflow", int'(ifc.overflow), 0);
        check("rst_drop_count", int'(ifc.drop_count), 0);
        check("rst_in_ready", int'(ifc.in_ready), 1);
        step();

        // Single character, exact timing
        push(8'h41, 1'b1);
        @(negedge clk);
        check("t1_level_after_push", int'(ifc.level), 1);
        check("t1_send_not_yet", int'(ifc.tx_send), 0);
        @(negedge clk);
        check("t1_send_rise", int'(ifc.tx_send), 1);
        check("t1_data", int'(ifc.tx_data), 8'h41);
        check("t1_level_popped", int'(ifc.level), 0);
        step();
        step();
        man_ready = 1'b0;
        step();
        @(negedge clk);
        check("t1_send_fall", int'(ifc.tx_send), 0);
        check("t1_level_end", int'(ifc.level), 0);
        step();
        man_ready = 1'b1;
        repeat (2) step();

        // Burst into a full FIFO while the controller is busy
        man_ready = 1'b0;
        for (int i = 0; i < 18; i++) push(8'(32'h60 + i), i < 16);
        @(negedge clk);
        check("t2_level_full", int'(ifc.level), 16);
        check("t2_in_ready", int'(ifc.in_ready), 0);
        check("t2_overflow", int'(ifc.overflow), 1);
        check("t2_drop_count", int'(ifc.drop_count), 2);
        step();
        ctl_manual = 1'b0;
        wait_send("t2_first_send");
        check("t2_in_ready_back", int'(ifc.in_ready), 1);
        check("t2_level_15", int'(ifc.level), 15);
        drain("t2_drain");

        // Drop counter saturation
        ctl_manual = 1'b1;
        man_ready  = 1'b0;
        step();
        for (int i = 0; i < 16; i++) push(8'(32'h80 + i), 1'b1);
        for (int i = 0; i < 300; i++) push(8'hEE, 1'b0);
        @(negedge clk);
        check("t3_drop_sat", int'(ifc.drop_count), 255);
        check("t3_level_full", int'(ifc.level), 16);
        step();
        ctl_manual = 1'b0;
        drain("t3_drain");

        // Handshake hold while the controller delays acceptance
        ctl_manual = 1'b1;
        man_ready  = 1'b0;
        step();
        push(8'h7E, 1'b1);
        push(8'h7F, 1'b1);
        man_ready = 1'b1;
        wait_send("t4_send");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t4_hold_send", int'(ifc.tx_send), 1);
            check("t4_hold_data", int'(ifc.tx_data), 8'h7E);
            check("t4_one_pop", int'(ifc.level), 1);
        end
        step();
        man_ready = 1'b0;
        step();
        @(negedge clk);
        check("t4_accepted", int'(ifc.tx_send), 0);
        check("t4_level_after", int'(ifc.level), 1);
        step();
        ctl_manual = 1'b0;
        drain("t4_drain");

        // Reset in the middle of a burst while a send is pending
        ctl_manual = 1'b1;
        man_ready  = 1'b0;
        step();
        for (int i = 0; i < 5; i++) push(8'(32'h31 + i), i == 0);
        man_ready = 1'b1;
        wait_send("t5_send");
        check("t5_level_4", int'(ifc.level), 4);
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("t5_send_dropped", int'(ifc.tx_send), 0);
        check("t5_level_0", int'(ifc.level), 0);
        check("t5_overflow_0", int'(ifc.overflow), 0);
        check("t5_drop_count_0", int'(ifc.drop_count), 0);
        step();
        push(8'h55, 1'b1);
        ctl_manual = 1'b0;
        drain("t5_drain");

        // LF handling, with or without CR insertion
`ifdef UART_TX_CRLF_EN
        sb.push_back(8'h0D);
`endif
        push(8'h0A, 1'b1);
        wait_send("t6_send");
`ifdef UART_TX_CRLF_EN
        check("t6_level_cr", int'(ifc.level), 1);
`else
        check("t6_level_lf", int'(ifc.level), 0);
`endif
        drain("t6_drain");

        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
